// File: rtl/spi_xfer_engine.sv
// SPI mode 0 master word engine for the MicroSD path.
// One N-bit word per start/ready handshake, DIV sclk cycles per half-period.
module spi_xfer_engine #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         sclk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] tx_data,
  input  logic         lsb_first,
  input  logic         hold_cs,
  input  logic         cs_en,
  output logic         ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         spi_clk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  tx_sh;
  logic [N-1:0]  rx_sh;
  logic [N-1:0]  rx_next;
  logic [N-1:0]  tx_adv;
  logic          tx_bit;
  logic          lsb_q;
  logic          hold_q;
  logic          div_done;

  assign div_done = (div_cnt == DIV_LAST);

  // tx_sh always holds the bits still to send, next one at the active end
  always_comb begin
    rx_next = lsb_q ? {miso, rx_sh[N-1:1]} : {rx_sh[N-2:0], miso};
    tx_bit  = lsb_q ? tx_sh[0] : tx_sh[N-1];
    tx_adv  = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
      ready    <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_clk  <= 1'b0;
      mosi     <= 1'b1;
      cs_n     <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            lsb_q   <= lsb_first;
            hold_q  <= hold_cs;
            tx_sh   <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
            mosi    <= lsb_first ? tx_data[0] : tx_data[N-1];
            cs_n    <= ~cs_en;
            ready   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            rx_sh   <= '0;
            state   <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (div_done) begin
            div_cnt <= '0;
            spi_clk <= 1'b1;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (div_done) begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
            rx_sh   <= rx_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              mosi     <= 1'b1;
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              ready    <= 1'b1;
              if (!hold_q) cs_n <= 1'b1;
              state    <= IDLE;
            end else begin
              mosi  <= tx_bit;
              tx_sh <= tx_adv;
              state <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/spi_xfer_engine.md
# spi_xfer_engine

Parametrised SPI master transfer engine for the MicroSD path. It generates mode 0 SPI clock and chip select from the system clock, and shifts one N-bit word out on MOSI while shifting one in from MISO. Each transfer uses a start/ready handshake. Bit order, chip-select hold between words and chip-select suppression are selected per transfer; suppression gives the SD init dummy clocks. It sits between the SD command/data controller and the card pins.

## Interface
- N, 8: word width in bits, 2..32
- DIV, 4: sclk cycles per SPI half-period, ≥1
- sclk  in  1  system clock; all logic is on posedge sclk
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request a transfer; accepted only when ready=1
- tx_data  in  N  word to send; sampled on the accept edge
- lsb_first  in  1  1 = LSB first, 0 = MSB first; sampled on accept
- hold_cs  in  1  1 = keep cs_n low after this word; sampled on accept
- cs_en  in  1  0 = cs_n stays high for this word (dummy clocks); sampled on accept
- ready  out  1  engine idle, can accept start
- rx_data  out  N  last received word; holds until the next completion
- rx_valid  out  1  one-cycle pulse when rx_data updates
- spi_clk  out  1  SPI clock, CPOL=0
- mosi  out  1  serial data out
- miso  in  1  serial data in
- cs_n  out  1  card select, active-low

## Operation
- Reset values: ready=1, spi_clk=0, mosi=1, cs_n=1, rx_valid=0, rx_data=0, FSM=IDLE, shift registers=0.
- Accept: on a posedge with start=1 and ready=1, the engine:
  - latches tx_data, lsb_first, hold_cs and cs_en;
  - drives ready=0;
  - drives cs_n to ~cs_en;
  - drives mosi to the first bit (tx_data[N-1] if MSB first, tx_data[0] if LSB first);
  - enters SETUP.
- start while ready=0 is ignored. tx_data and mode inputs have no effect mid-transfer.
- SETUP: lasts DIV cycles with spi_clk=0, then spi_clk goes to 1 and the FSM enters HIGH.
- HIGH: lasts DIV cycles. On the edge ending HIGH:
  - spi_clk goes to 0;
  - the engine samples miso into the rx shift register;
  - the bit counter increments.
  - If bits remain: mosi takes the next bit and the FSM enters LOW.
  - Otherwise the FSM enters IDLE and the completion actions below happen on that same edge.
- LOW: lasts DIV cycles, then spi_clk goes to 1 and the FSM enters HIGH.
- Completion (the edge ending the N-th HIGH):
  - mosi=1;
  - rx_data takes the assembled word, rx_valid=1 for exactly one cycle;
  - ready=1;
  - cs_n=1 if hold_cs=0, otherwise cs_n stays at its current value.
- Rx assembly: MSB first places the first received bit in rx_data[N-1]; LSB first places it in rx_data[0].
- Back-to-back: a start on the first ready=1 cycle is accepted. The new word still gets a full SETUP phase. cs_n is driven to ~cs_en of the new word.
- Dummy mode (cs_en=0): clocks and mosi behave identically, but cs_n stays 1 for the whole word. rx_data is still updated.
- Reset mid-transfer: all outputs return to their reset values immediately. No rx_valid pulse is produced, and the partial word is discarded.

## Timing
- Let T0 be the accept edge. Mode 0: mosi changes only while spi_clk=0 (at T0 or at a falling edge). The slave samples on rising edges.
- Bit k (k=0..N-1): spi_clk rises at T0+(2k+1)·DIV and falls at T0+(2k+2)·DIV.
- miso is sampled on the falling edge, i.e. with the value held through the high phase.
- Completion edge is T0+2N·DIV. rx_valid and ready are high in the following cycle.
- The earliest next accept is T0+2N·DIV+1, so the word period is 2N·DIV+1 cycles. Example: N=8, DIV=4 gives 65 cycles.
- cs_n setup to the first rising spi_clk is DIV cycles. cs_n hold after the last falling edge is 0 cycles; cs_n rises on that same edge.
- DIV=1 gives spi_clk = sclk/2. No combinational path from any input to any output.

## Test plan
- Reset: assert reset mid-idle and mid-transfer, then release. Required: ready=1, spi_clk=0, mosi=1, cs_n=1, rx_valid=0, rx_data=0, and no clocks until start.
- MSB transfer: N=8, DIV=4, tx 0xA5, slave model returns 0x3C. Required:
  - mosi at rising edges = 1,0,1,0,0,1,0,1;
  - 8 spi_clk pulses, each 4 high / 4 low cycles;
  - rx_data=0x3C with rx_valid on the cycle after T0+64;
  - cs_n=1 after completion.
- LSB transfer: lsb_first=1, tx 0x01, slave sends 1,0,0,0,0,0,0,0. Required: mosi = 1 then seven 0s, and rx_data=0x01.
- CS burst: 0x40 with hold_cs=1, then 0x95 with hold_cs=0 started the cycle ready rises. Required:
  - cs_n stays low continuously through both words;
  - two rx_valid pulses;
  - cs_n goes to 1 at the second completion.
- Dummy clocks: ten words of 0xFF with cs_en=0. Required: 80 spi_clk pulses, cs_n=1 throughout, mosi=1 throughout.
- Handshake: start held high during a busy transfer is ignored. tx_data changed mid-word does not alter mosi. DIV=1 gives a 17-cycle word period for N=8.
